banco_reg_sb: RTL and testbench
===============================

# banco_reg_sb

Parametrised successor to the 8-bit, 8-entry register bank. It is a 1-write/3-read register file with:
- a configurable link register that captures PC+1,
- same-cycle write-to-read forwarding,
- an optional hard-wired zero register,
- a per-register pending-write scoreboard with an occupancy counter, so the control unit can detect RAW hazards.

It sits between decode (read addresses, reservations) and write-back (write port) in the processor datapath.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; NREG = 2**ADDR_W registers
- LINK_REG, 5, index of the link register (0 ≤ LINK_REG < NREG)
- ZERO_R0, 0, 1 = register 0 reads as 0, ignores writes, never busy

Ports (clock and reset first):
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rd_addr_a / rd_addr_b / rd_addr_s  in  ADDR_W each  read addresses (operand A, operand B, subsequent)
- rd_data_a / rd_data_b / rd_data_s  out  DATA_W each  read data, combinational
- rd_busy_a / rd_busy_b / rd_busy_s  out  1 each  pending-write flag for the addressed register
- wr_en  in  1  write-back strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve request: mark rsv_addr pending
- rsv_addr  in  ADDR_W  register to reserve
- link_en  in  1  load LINK_REG with pc_value+1 this cycle
- pc_value  in  DATA_W  current PC
- pend_cnt  out  ADDR_W+1  number of registers currently busy (registered)

## Operation
- Reset (reset=1 at a rising edge):
  - all registers, busy bits and pend_cnt go to 0.
  - rsv_en, wr_en and link_en in that cycle are ignored.
  - Reset mid-operation discards all pending reservations.
- Write: wr_en=1 stores wr_data into wr_addr and clears busy[wr_addr].
- Link update: link_en=1 stores pc_value+1 into LINK_REG.
  - The sum is truncated to DATA_W, so 0xFF+1 = 0x00 at DATA_W=8.
  - Link update is gated by link_en; it is not unconditional every cycle.
- Write and link to the same register in one cycle: if wr_en=1 and wr_addr=LINK_REG while link_en=1, the explicit write wins.
- Reserve: rsv_en=1 sets busy[rsv_addr].
  - Reserve and write to the same address in one cycle: data is written and busy stays 1, because a newer producer is in flight.
  - Reserving an already-busy register leaves pend_cnt unchanged.
- pend_cnt always equals the population count of the busy vector after the edge. It is maintained incrementally (+1, −1 or 0 per cycle) and never wraps.
- Reads (combinational, per port, in priority order):
  - ZERO_R0=1 and address 0 → data 0, busy 0.
  - wr_en=1 and address = wr_addr → wr_data, busy 0 (forwarded).
  - link_en=1, address = LINK_REG, and no explicit write to LINK_REG → pc_value+1, busy 0.
  - Otherwise → stored value and stored busy bit.
- ZERO_R0=1 and address 0 targeted by a write or reserve: the write is ignored, no busy bit is set, and pend_cnt is unaffected.
- Any combination of the three read ports may address the same register.

## Timing
- Read latency: 0 cycles (combinational from addresses and write/link inputs).
- Write, link, reserve and pend_cnt take effect at the rising edge where the request is sampled; they are visible as stored state from the next cycle.
- Forwarding makes a write visible on read ports in the same cycle it is presented.
- No handshake: the block never stalls. Hazard stalling is the consumer's decision, based on rd_busy_*.
- No combinational path from rsv_* to any read output.

## Structure
- The shared processor package holds:
  - the default DATA_W/ADDR_W constants;
  - the LINK_REG index constant;
  - the register-index names (link register, subsequent register), so the decoder and this block agree.
- One natural sub-module, banco_reg_read_port: the forwarding/zero mux plus busy lookup, instantiated three times.
- Storage, busy vector and pend_cnt counter live in the top module.

## Test plan
- Reset, then read all 8 addresses → data 0x00, busy 0, pend_cnt 0.
- wr_en, wr_addr=3, wr_data=0xA5 with rd_addr_a=3 in the same cycle → rd_data_a=0xA5 that cycle; next cycle stored value reads 0xA5.
- link_en, pc_value=0xFF with rd_addr_s=5 → rd_data_s=0x00. Then link_en with wr_en, wr_addr=5, wr_data=0x42 → register 5 holds 0x42 after the edge.
- rsv_en addr 2, then addr 4 → pend_cnt 1 then 2, rd_busy on 2 reads 1. wr_en addr 2 → busy clears, pend_cnt 1. Then same-cycle rsv_en and wr_en on addr 4 → busy stays 1, data updated, pend_cnt 1.
- ZERO_R0=1: wr_en addr 0 data 0x7E plus rsv_en addr 0 → reads 0x00, busy 0, pend_cnt unchanged.
- Reserve 3 registers, assert reset mid-sequence with wr_en active → all busy 0, pend_cnt 0, all data 0x00 on the next cycle.

Source files
------------

// File: rtl/banco_reg_sb_pkg.sv
// Shared processor constants for the register bank.
// The decoder imports the same register-index names, so both sides agree on them.
package banco_reg_sb_pkg;

    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned ADDR_W_DEF   = 3;
    localparam int unsigned LINK_REG_IDX = 5;

    // REG_LINK must stay equal to LINK_REG_IDX.
    typedef enum logic [2:0] {
        REG_ZERO   = 3'd0,
        REG_LINK   = 3'd5,
        REG_SUBSEQ = 3'd6
    } reg_name_e;

endpackage

// File: rtl/banco_reg_read_port.sv
// One combinational read port: hard-zero, write forwarding, link forwarding,
// then the stored value and its stored busy bit.
module banco_reg_read_port
    import banco_reg_sb_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned LINK_REG = LINK_REG_IDX,
    parameter bit          ZERO_R0  = 1'b0
) (
    input  logic [ADDR_W-1:0]                         rd_addr_i,
    input  logic                                      wr_en_i,
    input  logic [ADDR_W-1:0]                         wr_addr_i,
    input  logic [DATA_W-1:0]                         wr_data_i,
    input  logic                                      link_en_i,
    input  logic [DATA_W-1:0]                         link_data_i,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]        regs_i,
    input  logic [(1<<ADDR_W)-1:0]                    busy_i,
    output logic [DATA_W-1:0]                         rd_data_o,
    output logic                                      rd_busy_o
);

    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    logic hit_zero_s;
    logic hit_wr_s;
    logic hit_link_s;

    // Classify the read address against the in-flight write and link update.
    always_comb begin
        hit_zero_s = (ZERO_R0 == 1'b1) && (rd_addr_i == {ADDR_W{1'b0}});
        hit_wr_s   = wr_en_i && (rd_addr_i == wr_addr_i);
        hit_link_s = link_en_i && (rd_addr_i == LINK_A)
                     && !(wr_en_i && (wr_addr_i == LINK_A));
    end

    // Priority mux; a forwarded value is by definition no longer pending.
    always_comb begin
        rd_data_o = regs_i[rd_addr_i];
        rd_busy_o = busy_i[rd_addr_i];
        if (hit_zero_s) begin
            rd_data_o = {DATA_W{1'b0}};
            rd_busy_o = 1'b0;
        end else if (hit_wr_s) begin
            rd_data_o = wr_data_i;
            rd_busy_o = 1'b0;
        end else if (hit_link_s) begin
            rd_data_o = link_data_i;
            rd_busy_o = 1'b0;
        end else begin
            rd_data_o = regs_i[rd_addr_i];
            rd_busy_o = busy_i[rd_addr_i];
        end
    end

endmodule

// File: rtl/banco_reg_sb.sv
// 1-write/3-read register file with link register, forwarding, optional zero
// register and a pending-write scoreboard with occupancy counter.
module banco_reg_sb
    import banco_reg_sb_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned LINK_REG = LINK_REG_IDX,
    parameter bit          ZERO_R0  = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] rd_addr_s,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] rd_data_s,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    output logic              rd_busy_s,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              link_en,
    input  logic [DATA_W-1:0] pc_value,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int unsigned       NREG   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};

    logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NREG-1:0]             busy_q, busy_d;
    logic [ADDR_W:0]             cnt_q, cnt_d;

    logic [DATA_W-1:0] link_data_s;
    logic              wr_eff_s;
    logic              rsv_eff_s;
    logic              link_eff_s;
    logic              inc_s;
    logic              dec_s;

    // Qualify requests: register 0 may be hard-wired, and a write beats the link.
    always_comb begin
        link_data_s = pc_value + {{(DATA_W-1){1'b0}}, 1'b1};
        wr_eff_s    = wr_en  && !((ZERO_R0 == 1'b1) && (wr_addr  == ZERO_A));
        rsv_eff_s   = rsv_en && !((ZERO_R0 == 1'b1) && (rsv_addr == ZERO_A));
        link_eff_s  = link_en && !(wr_eff_s && (wr_addr == LINK_A))
                      && !((ZERO_R0 == 1'b1) && (LINK_A == ZERO_A));
    end

    // Next storage and busy state; a same-cycle reserve keeps the entry busy.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = (wr_eff_s && (wr_addr == ADDR_W'(i))) ? wr_data :
                        (link_eff_s && (LINK_A == ADDR_W'(i))) ? link_data_s :
                        regs_q[i];
            busy_d[i] = (rsv_eff_s && (rsv_addr == ADDR_W'(i))) ? 1'b1 :
                        (wr_eff_s && (wr_addr == ADDR_W'(i))) ? 1'b0 :
                        busy_q[i];
        end
    end

    // Occupancy moves by at most one per cycle in each direction, so it never wraps.
    always_comb begin
        inc_s = rsv_eff_s && !busy_q[rsv_addr];
        dec_s = wr_eff_s && busy_q[wr_addr]
                && !(rsv_eff_s && (rsv_addr == wr_addr));
        cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc_s} - {{ADDR_W{1'b0}}, dec_s};
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= {(NREG*DATA_W){1'b0}};
            busy_q <= {NREG{1'b0}};
            cnt_q  <= {(ADDR_W+1){1'b0}};
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt = cnt_q;

    banco_reg_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINK_REG(LINK_REG), .ZERO_R0(ZERO_R0)
    ) u_port_a (
        .rd_addr_i(rd_addr_a), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .link_en_i(link_en), .link_data_i(link_data_s),
        .regs_i(regs_q), .busy_i(busy_q),
        .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a)
    );

    banco_reg_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINK_REG(LINK_REG), .ZERO_R0(ZERO_R0)
    ) u_port_b (
        .rd_addr_i(rd_addr_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .link_en_i(link_en), .link_data_i(link_data_s),
        .regs_i(regs_q), .busy_i(busy_q),
        .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b)
    );

    banco_reg_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINK_REG(LINK_REG), .ZERO_R0(ZERO_R0)
    ) u_port_s (
        .rd_addr_i(rd_addr_s), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .link_en_i(link_en), .link_data_i(link_data_s),
        .regs_i(regs_q), .busy_i(busy_q),
        .rd_data_o(rd_data_s), .rd_busy_o(rd_busy_s)
    );

endmodule

// File: tb/tb_banco_reg_sb.sv
// Bench for banco_reg_sb: two instances (ZERO_R0=0 and ZERO_R0=1) share stimulus
// and are compared against a register-array reference model.
module tb_banco_reg_sb;

    logic       clock;
    logic       reset;
    logic [2:0] rd_addr_a, rd_addr_b, rd_addr_s;
    logic       wr_en, rsv_en, link_en;
    logic [2:0] wr_addr, rsv_addr;
    logic [7:0] wr_data, pc_value;

    logic [7:0] d0a, d0b, d0s, d1a, d1b, d1s;
    logic       b0a, b0b, b0s, b1a, b1b, b1s;
    logic [3:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_reg  [2][8];
    logic       m_busy [2][8];

    banco_reg_sb #(.DATA_W(8), .ADDR_W(3), .LINK_REG(5), .ZERO_R0(1'b0)) dut0 (
        .clock(clock), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_s(rd_addr_s),
        .rd_data_a(d0a), .rd_data_b(d0b), .rd_data_s(d0s),
        .rd_busy_a(b0a), .rd_busy_b(b0b), .rd_busy_s(b0s),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .link_en(link_en), .pc_value(pc_value), .pend_cnt(cnt0)
    );

    banco_reg_sb #(.DATA_W(8), .ADDR_W(3), .LINK_REG(5), .ZERO_R0(1'b1)) dut1 (
        .clock(clock), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_s(rd_addr_s),
        .rd_data_a(d1a), .rd_data_b(d1b), .rd_data_s(d1s),
        .rd_busy_a(b1a), .rd_busy_b(b1b), .rd_busy_s(b1s),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .link_en(link_en), .pc_value(pc_value), .pend_cnt(cnt1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       we;  logic [2:0] wa;  logic [7:0] wd;
        logic       re;  logic [2:0] ra;
        logic       le;  logic [7:0] pc;
        logic [2:0] rda; logic [2:0] rds;
        logic [7:0] exp_a; logic exp_ba; logic [7:0] exp_s; logic [3:0] exp_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Reference read: the spec's priority list applied to the model arrays.
    function automatic void mread(input int v, input logic [2:0] a,
                                  output logic [7:0] d, output logic b);
        if (v == 1 && a == 3'd0) begin
            d = 8'h00; b = 1'b0;
        end else if (wr_en && a == wr_addr) begin
            d = wr_data; b = 1'b0;
        end else if (link_en && a == 3'd5 && !(wr_en && wr_addr == 3'd5)) begin
            d = pc_value + 8'd1; b = 1'b0;
        end else begin
            d = m_reg[v][a]; b = m_busy[v][a];
        end
    endfunction

    function automatic int mcount(input int v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_busy[v][i]);
        return n;
    endfunction

    task automatic model_edge();
        for (int v = 0; v < 2; v++) begin
            if (reset) begin
                for (int i = 0; i < 8; i++) begin
                    m_reg[v][i] = 8'h00; m_busy[v][i] = 1'b0;
                end
            end else begin
                if (link_en) m_reg[v][5] = pc_value + 8'd1;
                if (wr_en && !(v == 1 && wr_addr == 3'd0)) begin
                    m_reg[v][wr_addr]  = wr_data;
                    m_busy[v][wr_addr] = 1'b0;
                end
                if (rsv_en && !(v == 1 && rsv_addr == 3'd0)) m_busy[v][rsv_addr] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] d [2][3];
        logic       b [2][3];
        logic [2:0] ad [3];
        logic [7:0] ed; logic eb;
        d = '{'{d0a, d0b, d0s}, '{d1a, d1b, d1s}};
        b = '{'{b0a, b0b, b0s}, '{b1a, b1b, b1s}};
        ad = '{rd_addr_a, rd_addr_b, rd_addr_s};
        for (int v = 0; v < 2; v++) begin
            for (int p = 0; p < 3; p++) begin
                mread(v, ad[p], ed, eb);
                chk($sformatf("model_data_v%0d_p%0d_a%0d", v, p, ad[p]), 32'(d[v][p]), 32'(ed));
                chk($sformatf("model_busy_v%0d_p%0d_a%0d", v, p, ad[p]), 32'(b[v][p]), 32'(eb));
            end
        end
        chk("model_cnt_v0", 32'(cnt0), 32'(mcount(0)));
        chk("model_cnt_v1", 32'(cnt1), 32'(mcount(1)));
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
        rsv_en = 1'b0; rsv_addr = 3'd0; link_en = 1'b0; pc_value = 8'h00;
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 3'd3, 3'd5, 8'h00, 1'b0, 8'h00, 4'd0};
        tbl[1]  = '{1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0, 8'h00, 3'd3, 3'd5, 8'hA5, 1'b0, 8'h00, 4'd0};
        tbl[2]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 3'd3, 3'd5, 8'hA5, 1'b0, 8'h00, 4'd0};
        tbl[3]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 8'hFF, 3'd3, 3'd5, 8'hA5, 1'b0, 8'h00, 4'd0};
        tbl[4]  = '{1'b1, 3'd5, 8'h42, 1'b0, 3'd0, 1'b1, 8'h10, 3'd5, 3'd5, 8'h42, 1'b0, 8'h42, 4'd0};
        tbl[5]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 8'h00, 3'd5, 3'd5, 8'h42, 1'b0, 8'h42, 4'd0};
        tbl[6]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b0, 8'h00, 3'd2, 3'd5, 8'h00, 1'b1, 8'h42, 4'd1};
        tbl[7]  = '{1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 1'b0, 8'h00, 3'd2, 3'd5, 8'h11, 1'b0, 8'h42, 4'd2};
        tbl[8]  = '{1'b1, 3'd4, 8'h99, 1'b1, 3'd4, 1'b0, 8'h00, 3'd2, 3'd4, 8'h11, 1'b0, 8'h99, 4'd1};
        tbl[9]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 3'd4, 3'd4, 8'h99, 1'b1, 8'h99, 4'd1};
        tbl[10] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b0, 8'h00, 3'd4, 3'd4, 8'h99, 1'b1, 8'h99, 4'd1};
        tbl[11] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 3'd4, 3'd4, 8'h99, 1'b1, 8'h99, 4'd1};

        idle();
        reset = 1'b1;
        rd_addr_a = 3'd0; rd_addr_b = 3'd0; rd_addr_s = 3'd0;
        @(negedge clock);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(i); rd_addr_s = 3'(i);
            #1;
            chk($sformatf("reset_data_a%0d", i), 32'(d0a), 32'h00);
            chk($sformatf("reset_busy_a%0d", i), 32'(b0a), 32'h0);
            chk("reset_cnt", 32'(cnt0), 32'h0);
            check_all();
            @(negedge clock);
        end

        for (int k = 0; k < 12; k++) begin
            wr_en = tbl[k].we; wr_addr = tbl[k].wa; wr_data = tbl[k].wd;
            rsv_en = tbl[k].re; rsv_addr = tbl[k].ra;
            link_en = tbl[k].le; pc_value = tbl[k].pc;
            rd_addr_a = tbl[k].rda; rd_addr_b = tbl[k].rda; rd_addr_s = tbl[k].rds;
            #1;
            chk($sformatf("tbl%0d_data_a", k), 32'(d0a), 32'(tbl[k].exp_a));
            chk($sformatf("tbl%0d_busy_a", k), 32'(b0a), 32'(tbl[k].exp_ba));
            chk($sformatf("tbl%0d_data_s", k), 32'(d0s), 32'(tbl[k].exp_s));
            chk($sformatf("tbl%0d_cnt", k), 32'(cnt0), 32'(tbl[k].exp_cnt));
            check_all();
            tick();
        end

        // Hard-zero register: write and reserve to address 0.
        idle();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h7E; rsv_en = 1'b1; rsv_addr = 3'd0;
        rd_addr_a = 3'd0; rd_addr_b = 3'd0; rd_addr_s = 3'd0;
        #1;
        chk("zero_fwd_data_z1", 32'(d1a), 32'h00);
        chk("zero_fwd_busy_z1", 32'(b1a), 32'h0);
        chk("zero_fwd_data_z0", 32'(d0a), 32'h7E);
        check_all();
        tick();
        idle();
        #1;
        chk("zero_store_data_z1", 32'(d1s), 32'h00);
        chk("zero_store_busy_z1", 32'(b1s), 32'h0);
        chk("zero_store_cnt_z1", 32'(cnt1), 32'd1);
        chk("zero_store_data_z0", 32'(d0s), 32'h7E);
        chk("zero_store_busy_z0", 32'(b0s), 32'h1);
        chk("zero_store_cnt_z0", 32'(cnt0), 32'd2);
        check_all();

        // Reserve three more, then reset with traffic active.
        for (int i = 0; i < 3; i++) begin
            idle();
            rsv_en = 1'b1; rsv_addr = (i == 0) ? 3'd1 : (i == 1) ? 3'd3 : 3'd6;
            #1; check_all();
            tick();
        end
        idle();
        #1;
        chk("pre_reset_cnt_z0", 32'(cnt0), 32'd5);
        chk("pre_reset_cnt_z1", 32'(cnt1), 32'd4);
        reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h55;
        rsv_en = 1'b1; rsv_addr = 3'd7; link_en = 1'b1; pc_value = 8'h20;
        tick();
        reset = 1'b0; idle();
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(i); rd_addr_s = 3'(i);
            #1;
            chk($sformatf("midreset_data_z0_%0d", i), 32'(d0b), 32'h00);
            chk($sformatf("midreset_busy_z0_%0d", i), 32'(b0b), 32'h0);
            chk($sformatf("midreset_data_z1_%0d", i), 32'(d1b), 32'h00);
            chk($sformatf("midreset_busy_z1_%0d", i), 32'(b1b), 32'h0);
            chk("midreset_cnt_z0", 32'(cnt0), 32'd0);
            chk("midreset_cnt_z1", 32'(cnt1), 32'd0);
            @(negedge clock);
        end

        // Randomised traffic against the model, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 59) == 0);
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom);
            rsv_en   = 1'($urandom_range(0, 1));
            rsv_addr = (n % 4 == 0) ? wr_addr : 3'($urandom_range(0, 7));
            link_en  = ($urandom_range(0, 3) == 0);
            pc_value = (n % 16 == 0) ? 8'hFF : 8'($urandom);
            rd_addr_a = 3'($urandom_range(0, 7));
            rd_addr_b = (n % 3 == 0) ? rd_addr_a : 3'($urandom_range(0, 7));
            rd_addr_s = (n % 5 == 0) ? wr_addr : 3'($urandom_range(0, 7));
            #1;
            check_all();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
